// File: rtl/spi_sram_pkg.sv
// Shared command codes, state encoding and helpers for the SPI serial-SRAM responder.
package spi_sram_pkg;

    localparam logic [7:0] CMD_READ        = 8'h03;
    localparam logic [7:0] CMD_WRITE       = 8'h02;
    localparam int         FRAME_ADDR_BITS = 16;
    localparam int         BIT_CNT_W       = 5;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CMD    = 3'd1,
        ADDR   = 3'd2,
        WRITE  = 3'd3,
        READ   = 3'd4,
        IGNORE = 3'd5
    } resp_state_t;

    // Next value of a bit counter that counts up to last_idx and then restarts at 0.
    function automatic logic [BIT_CNT_W-1:0] bit_cnt_next(input logic [BIT_CNT_W-1:0] cnt,
                                                          input logic [BIT_CNT_W-1:0] last_idx);
        logic [BIT_CNT_W-1:0] nxt;
        if (cnt == last_idx) begin
            nxt = {BIT_CNT_W{1'b0}};
        end else begin
            nxt = cnt + {{(BIT_CNT_W-1){1'b0}}, 1'b1};
        end
        return nxt;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for one SPI pin with registered level and one-cycle rise/fall pulses.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_r;
    logic              level_r;
    logic              rise_r;
    logic              fall_r;

    // Metastability chain; bit 0 samples the asynchronous pin (STAGES must be at least 2).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {STAGES{RST_VAL}};
        end else begin
            sync_r <= {sync_r[STAGES-2:0], din};
        end
    end

    // Registered level and edge pulses: both appear STAGES+1 clocks after the pin moves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_r <= RST_VAL;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            level_r <= sync_r[STAGES-1];
            rise_r  <= sync_r[STAGES-1] & ~level_r;
            fall_r  <= ~sync_r[STAGES-1] & level_r;
        end
    end

    assign level = level_r;
    assign rise  = rise_r;
    assign fall  = fall_r;

endmodule

// File: rtl/spi_sram_responder.sv
// SPI mode-0 target emulating a 23LC512-style SRAM (READ/WRITE, 16-bit address, sequential burst)
// on a byte-wide synchronous memory port; all SPI pins are oversampled in the clk domain.
module spi_sram_responder
    import spi_sram_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_clk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [ADDR_W-1:0] mem_adr,
    output logic              mem_we,
    output logic [7:0]        mem_wdat,
    output logic              mem_re,
    input  logic [7:0]        mem_rdat
);

    localparam int FLUSH_CYC = SYNC_STAGES + 2;
    localparam int FLUSH_W   = $clog2(FLUSH_CYC + 1);

    logic sck_level_unused_s;
    logic sck_rise_s;
    logic sck_fall_s;
    logic cs_level_s;
    logic cs_rise_s;
    logic cs_fall_s;
    logic mosi_s;
    logic mosi_rise_unused_s;
    logic mosi_fall_unused_s;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (spi_clk),
        .level (sck_level_unused_s),
        .rise  (sck_rise_s),
        .fall  (sck_fall_s)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (spi_cs_n),
        .level (cs_level_s),
        .rise  (cs_rise_s),
        .fall  (cs_fall_s)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (spi_mosi),
        .level (mosi_s),
        .rise  (mosi_rise_unused_s),
        .fall  (mosi_fall_unused_s)
    );

    logic [FLUSH_W-1:0] flush_cnt_r;
    logic               armed_r;

    // A CS that is already low when reset releases must not start a frame: wait for the
    // synchronizers to flush, then only arm once CS has been seen high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt_r <= {FLUSH_W{1'b0}};
            armed_r     <= 1'b0;
        end else if (flush_cnt_r != FLUSH_W'(FLUSH_CYC)) begin
            flush_cnt_r <= flush_cnt_r + FLUSH_W'(1);
            armed_r     <= 1'b0;
        end else if (cs_level_s) begin
            flush_cnt_r <= flush_cnt_r;
            armed_r     <= 1'b1;
        end else begin
            flush_cnt_r <= flush_cnt_r;
            armed_r     <= armed_r;
        end
    end

    resp_state_t          state_r;
    logic [BIT_CNT_W-1:0] bit_cnt_r;
    logic [15:0]          shift_r;
    logic [15:0]          shift_next_s;
    logic [ADDR_W-1:0]    addr_r;
    logic [ADDR_W-1:0]    addr_next_s;
    logic                 is_read_r;
    logic                 skip_fall_r;
    logic                 rd_req_r;
    logic                 rd_cap_r;
    logic                 rd_to_tx_r;
    logic [7:0]           tx_r;
    logic [7:0]           pf_r;
    logic                 miso_r;
    logic [ADDR_W-1:0]    mem_adr_r;
    logic                 mem_we_r;
    logic [7:0]           mem_wdat_r;
    logic                 mem_re_r;

    assign shift_next_s = {shift_r[14:0], mosi_s};
    assign addr_next_s  = addr_r + ADDR_W'(1);

    // Frame decoder. Read data path: rd_req_r marks the strobe cycle, rd_cap_r the cycle in
    // which mem_rdat is valid; rd_to_tx_r steers that byte to TX (first byte) or the prefetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            bit_cnt_r   <= {BIT_CNT_W{1'b0}};
            shift_r     <= 16'h0000;
            addr_r      <= {ADDR_W{1'b0}};
            is_read_r   <= 1'b0;
            skip_fall_r <= 1'b0;
            rd_req_r    <= 1'b0;
            rd_cap_r    <= 1'b0;
            rd_to_tx_r  <= 1'b0;
            tx_r        <= 8'h00;
            pf_r        <= 8'h00;
            miso_r      <= 1'b0;
            mem_adr_r   <= {ADDR_W{1'b0}};
            mem_we_r    <= 1'b0;
            mem_wdat_r  <= 8'h00;
            mem_re_r    <= 1'b0;
        end else begin
            mem_we_r <= 1'b0;
            mem_re_r <= 1'b0;
            rd_req_r <= 1'b0;
            rd_cap_r <= rd_req_r;
            if ((state_r != IDLE) && cs_rise_s) begin
                // CS rising wins over any same-cycle SCK edge; partial bytes and prefetches drop.
                state_r     <= IDLE;
                bit_cnt_r   <= {BIT_CNT_W{1'b0}};
                miso_r      <= 1'b0;
                skip_fall_r <= 1'b0;
                rd_cap_r    <= 1'b0;
                rd_to_tx_r  <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (cs_fall_s && armed_r) begin
                            state_r   <= CMD;
                            bit_cnt_r <= {BIT_CNT_W{1'b0}};
                        end
                    end
                    CMD: begin
                        if (sck_rise_s) begin
                            shift_r   <= shift_next_s;
                            bit_cnt_r <= bit_cnt_next(bit_cnt_r, 5'd7);
                            if (bit_cnt_r == 5'd7) begin
                                if (shift_next_s[7:0] == CMD_WRITE) begin
                                    is_read_r <= 1'b0;
                                    state_r   <= ADDR;
                                end else if (shift_next_s[7:0] == CMD_READ) begin
                                    is_read_r <= 1'b1;
                                    state_r   <= ADDR;
                                end else begin
                                    state_r   <= IGNORE;
                                end
                            end
                        end
                    end
                    ADDR: begin
                        if (sck_rise_s) begin
                            shift_r   <= shift_next_s;
                            bit_cnt_r <= bit_cnt_next(bit_cnt_r, 5'd15);
                            if (bit_cnt_r == 5'd15) begin
                                addr_r <= shift_next_s[ADDR_W-1:0];
                                if (is_read_r) begin
                                    mem_re_r    <= 1'b1;
                                    mem_adr_r   <= shift_next_s[ADDR_W-1:0];
                                    rd_req_r    <= 1'b1;
                                    rd_to_tx_r  <= 1'b1;
                                    skip_fall_r <= 1'b1;
                                    state_r     <= READ;
                                end else begin
                                    state_r     <= WRITE;
                                end
                            end
                        end
                    end
                    WRITE: begin
                        if (sck_rise_s) begin
                            shift_r   <= shift_next_s;
                            bit_cnt_r <= bit_cnt_next(bit_cnt_r, 5'd7);
                            if (bit_cnt_r == 5'd7) begin
                                mem_we_r   <= 1'b1;
                                mem_wdat_r <= shift_next_s[7:0];
                                mem_adr_r  <= addr_r;
                                addr_r     <= addr_next_s;
                            end
                        end
                    end
                    READ: begin
                        if (rd_cap_r) begin
                            if (rd_to_tx_r) begin
                                tx_r       <= mem_rdat;
                                miso_r     <= mem_rdat[7];
                                rd_to_tx_r <= 1'b0;
                                mem_re_r   <= 1'b1;
                                mem_adr_r  <= addr_next_s;
                                addr_r     <= addr_next_s;
                                rd_req_r   <= 1'b1;
                            end else begin
                                pf_r <= mem_rdat;
                            end
                        end
                        // The first falling edge belongs to the last address bit, not to data.
                        if (sck_fall_s) begin
                            if (skip_fall_r) begin
                                skip_fall_r <= 1'b0;
                            end else if (bit_cnt_r == 5'd7) begin
                                tx_r      <= pf_r;
                                miso_r    <= pf_r[7];
                                bit_cnt_r <= {BIT_CNT_W{1'b0}};
                                mem_re_r  <= 1'b1;
                                mem_adr_r <= addr_next_s;
                                addr_r    <= addr_next_s;
                                rd_req_r  <= 1'b1;
                            end else begin
                                tx_r      <= {tx_r[6:0], 1'b0};
                                miso_r    <= tx_r[6];
                                bit_cnt_r <= bit_cnt_r + 5'd1;
                            end
                        end
                    end
                    IGNORE: begin
                        miso_r <= 1'b0;
                    end
                    default: begin
                        state_r <= IDLE;
                        miso_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign spi_miso = miso_r;
    assign mem_adr  = mem_adr_r;
    assign mem_we   = mem_we_r;
    assign mem_wdat = mem_wdat_r;
    assign mem_re   = mem_re_r;

endmodule

// File: tb/tb_spi_sram_responder.sv
// Directed bench for spi_sram_responder: SPI initiator tasks, a byte memory model and strobe monitor.
module tb_spi_sram_responder;

    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        spi_clk;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        spi_miso;
    logic [15:0] mem_adr;
    logic        mem_we;
    logic [7:0]  mem_wdat;
    logic        mem_re;
    logic [7:0]  mem_rdat;

    logic [7:0]  mem [0:65535];
    logic        pre_we = 1'b0;
    logic [15:0] pre_adr = 16'h0000;
    logic [7:0]  pre_dat = 8'h00;

    int          total = 0;
    int          passed = 0;
    int          we_cnt = 0;
    int          re_cnt = 0;
    int          both_cnt = 0;
    int          miso_hi = 0;
    logic        in_read = 1'b0;
    logic [15:0] we_adr_log [0:63];
    logic [7:0]  we_dat_log [0:63];

    spi_sram_responder #(.ADDR_W(16), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .spi_clk  (spi_clk),
        .spi_cs_n (spi_cs_n),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .mem_adr  (mem_adr),
        .mem_we   (mem_we),
        .mem_wdat (mem_wdat),
        .mem_re   (mem_re),
        .mem_rdat (mem_rdat)
    );

    always #5 clk = ~clk;

    // Synchronous byte memory: read data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_we) mem[mem_adr] <= mem_wdat;
        else if (pre_we) mem[pre_adr] <= pre_dat;
        if (mem_re) mem_rdat <= mem[mem_adr];
    end

    // Strobe and MISO observer, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_we) begin
            we_adr_log[we_cnt % 64] = mem_adr;
            we_dat_log[we_cnt % 64] = mem_wdat;
            we_cnt = we_cnt + 1;
        end
        if (mem_re) re_cnt = re_cnt + 1;
        if (mem_we && mem_re) both_cnt = both_cnt + 1;
        if (!in_read && (spi_miso !== 1'b0)) miso_hi = miso_hi + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_adr = a; pre_dat = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int k = 0; k < n; k++) begin
            spi_mosi = tx[7-k];
            repeat (HALF) @(negedge clk);
            spi_clk = 1'b1;
            rx[7-k] = spi_miso;
            repeat (HALF) @(negedge clk);
            spi_clk = 1'b0;
        end
    endtask

    task automatic spi_start();
        spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic spi_stop();
        repeat (HALF) @(negedge clk);
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        repeat (4 * HALF) @(negedge clk);
    endtask

    logic [7:0]  rb;
    logic [31:0] rx32;
    int          wb;
    int          rbase;
    int          mbase;

    initial begin
        rst_n = 1'b0; spi_clk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_miso", 32'(spi_miso), 32'h0);
        check("rst_we",   32'(mem_we),   32'h0);
        check("rst_re",   32'(mem_re),   32'h0);
        check("rst_adr",  32'(mem_adr),  32'h0);
        check("rst_wdat", 32'(mem_wdat), 32'h0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Single write 02 00 10 A5
        wb = we_cnt; rbase = re_cnt; mbase = miso_hi;
        spi_start();
        spi_bits(8'h02, 8, rb); spi_bits(8'h00, 8, rb); spi_bits(8'h10, 8, rb); spi_bits(8'hA5, 8, rb);
        spi_stop();
        check("wr1_cnt",  32'(we_cnt - wb), 32'd1);
        check("wr1_adr",  32'(we_adr_log[wb % 64]), 32'h0010);
        check("wr1_dat",  32'(we_dat_log[wb % 64]), 32'h00A5);
        check("wr1_miso", 32'(miso_hi - mbase), 32'd0);
        check("wr1_nore", 32'(re_cnt - rbase), 32'd0);

        // Sequential read 03 00 04 -> 11 22 33 44
        preload(16'h0004, 8'h11); preload(16'h0005, 8'h22);
        preload(16'h0006, 8'h33); preload(16'h0007, 8'h44);
        wb = we_cnt;
        in_read = 1'b1;
        spi_start();
        spi_bits(8'h03, 8, rb); spi_bits(8'h00, 8, rb); spi_bits(8'h04, 8, rb);
        spi_bits(8'h00, 8, rb); rx32[31:24] = rb;
        spi_bits(8'h00, 8, rb); rx32[23:16] = rb;
        spi_bits(8'h00, 8, rb); rx32[15:8]  = rb;
        spi_bits(8'h00, 8, rb); rx32[7:0]   = rb;
        spi_stop();
        in_read = 1'b0;
        check("rd_data", rx32, 32'h11223344);
        check("rd_nowe", 32'(we_cnt - wb), 32'd0);

        // Burst write across the top of the address space
        wb = we_cnt;
        spi_start();
        spi_bits(8'h02, 8, rb); spi_bits(8'hFF, 8, rb); spi_bits(8'hFF, 8, rb);
        spi_bits(8'hAA, 8, rb); spi_bits(8'hBB, 8, rb);
        spi_stop();
        check("wrap_cnt",  32'(we_cnt - wb), 32'd2);
        check("wrap_adr0", 32'(we_adr_log[wb % 64]), 32'hFFFF);
        check("wrap_dat0", 32'(we_dat_log[wb % 64]), 32'h00AA);
        check("wrap_adr1", 32'(we_adr_log[(wb + 1) % 64]), 32'h0000);
        check("wrap_dat1", 32'(we_dat_log[(wb + 1) % 64]), 32'h00BB);

        // Unknown command 05 plus 24 clocks, then a valid write
        wb = we_cnt; rbase = re_cnt; mbase = miso_hi;
        spi_start();
        spi_bits(8'h05, 8, rb); spi_bits(8'hFF, 8, rb); spi_bits(8'h03, 8, rb); spi_bits(8'hFF, 8, rb);
        spi_stop();
        check("ign_nowe",  32'(we_cnt - wb), 32'd0);
        check("ign_nore",  32'(re_cnt - rbase), 32'd0);
        check("ign_miso",  32'(miso_hi - mbase), 32'd0);
        wb = we_cnt;
        spi_start();
        spi_bits(8'h02, 8, rb); spi_bits(8'h00, 8, rb); spi_bits(8'h01, 8, rb); spi_bits(8'h3C, 8, rb);
        spi_stop();
        check("post_ign_cnt", 32'(we_cnt - wb), 32'd1);
        check("post_ign_adr", 32'(we_adr_log[wb % 64]), 32'h0001);
        check("post_ign_dat", 32'(we_dat_log[wb % 64]), 32'h003C);

        // Write aborted after 4 data bits, then a fresh frame
        wb = we_cnt;
        spi_start();
        spi_bits(8'h02, 8, rb); spi_bits(8'h00, 8, rb); spi_bits(8'h20, 8, rb); spi_bits(8'hF0, 4, rb);
        spi_stop();
        check("abort_nowe", 32'(we_cnt - wb), 32'd0);
        wb = we_cnt;
        spi_start();
        spi_bits(8'h02, 8, rb); spi_bits(8'h00, 8, rb); spi_bits(8'h21, 8, rb); spi_bits(8'h5A, 8, rb);
        spi_stop();
        check("after_abort_cnt", 32'(we_cnt - wb), 32'd1);
        check("after_abort_adr", 32'(we_adr_log[wb % 64]), 32'h0021);
        check("after_abort_dat", 32'(we_dat_log[wb % 64]), 32'h005A);

        // Reset pulsed during the read data phase
        preload(16'h0100, 8'hC3); preload(16'h0101, 8'hFF); preload(16'h0102, 8'h5A);
        in_read = 1'b1;
        spi_start();
        spi_bits(8'h03, 8, rb); spi_bits(8'h01, 8, rb); spi_bits(8'h00, 8, rb);
        spi_bits(8'h00, 8, rb);
        check("rst_rd_byte0", 32'(rb), 32'h00C3);
        spi_bits(8'h00, 4, rb);
        rst_n = 1'b0;
        #1;
        check("midrst_miso", 32'(spi_miso), 32'h0);
        check("midrst_adr",  32'(mem_adr),  32'h0);
        check("midrst_re",   32'(mem_re),   32'h0);
        check("midrst_we",   32'(mem_we),   32'h0);
        in_read = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        wb = we_cnt; rbase = re_cnt; mbase = miso_hi;
        spi_bits(8'h02, 8, rb); spi_bits(8'h00, 8, rb); spi_bits(8'h00, 8, rb); spi_bits(8'h77, 8, rb);
        spi_stop();
        check("held_cs_nowe", 32'(we_cnt - wb), 32'd0);
        check("held_cs_nore", 32'(re_cnt - rbase), 32'd0);
        check("held_cs_miso", 32'(miso_hi - mbase), 32'd0);
        in_read = 1'b1;
        spi_start();
        spi_bits(8'h03, 8, rb); spi_bits(8'h01, 8, rb); spi_bits(8'h00, 8, rb);
        spi_bits(8'h00, 8, rb); rx32[15:8] = rb;
        spi_bits(8'h00, 8, rb); rx32[7:0]  = rb;
        spi_stop();
        in_read = 1'b0;
        check("post_rst_read", 32'(rx32[15:0]), 32'h0000C3FF);

        check("we_re_overlap", 32'(both_cnt), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
